tmds_src_sched: RTL and testbench
=================================

Name: tmds_src_sched

Overview:
- Frame-synchronous source scheduler between the clocked-video output stream and the three TMDS encoders, all in the pixclk domain.
- Selects per frame between the live video stream and an internal 8-bar colour test pattern locked to the stream timing.
- Inserts black mute frames on every source change.
- Forces the test pattern on video underflow; blanks on loss of vsync.

Parameters:
- H_ACTIVE, 1280, active pixels per line; bar width = H_ACTIVE/8, integer, remainder goes to bar 7.
- MUTE_FRAMES, 2, black frames inserted per source change; 0 means switch directly.
- VS_TIMEOUT, 2500000, CLK cycles without a vsync leading edge before NO_SIGNAL.
- VS_POL, 1, active level of in_vs.
- UF_HOLD_FRAMES, 4, consecutive underflow-free frames required before returning to video after forced TPG.

Ports:
- CLK  in  1  pixel clock (pixclk).
- RSTn  in  1  asynchronous active-low reset.
- in_data  in  24  R[23:16] G[15:8] B[7:0] from the video output.
- in_de  in  1  data valid.
- in_hs  in  1  hsync.
- in_vs  in  1  vsync.
- in_underflow  in  1  underflow flag from the video output.
- sel_tpg  in  1  1 = test pattern requested; asynchronous (PIO), synchronized internally.
- out_data  out  24  to encoders.
- out_de  out  1  to encoder VDE.
- out_hs  out  1  to encoder CD[0].
- out_vs  out  1  to encoder CD[1].
- active_src  out  1  0 = video, 1 = TPG (source currently driving out_data).
- state_o  out  3  FSM state code, for LED / 7-seg debug.

Behaviour:
- Reset: all outputs 0; state WAIT_SYNC; counters 0; sync flops 0.
- Latency: exactly 1 CLK on all outputs. out_de/hs/vs = in_de/hs/vs delayed one cycle in every state; timing is never gated.
- sel_tpg: 2-FF synchronizer, giving sel_s.
- Frame start (fs): cycle where in_vs transitions to VS_POL. All state changes occur only on fs, except entry to NO_SIGNAL.
- Pixel counter: 0 on in_de rising edge; +1 on each in_de=1 cycle; saturates at H_ACTIVE-1.
- Bar index: min(pix_cnt / (H_ACTIVE/8), 7).
- Bar colours 0..7: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Data:
  - out_data = 0 whenever in_de=0.
  - SHOW_VID: out_data = in_data.
  - SHOW_TPG: out_data = bar colour.
  - MUTE, WAIT_SYNC, NO_SIGNAL: out_data = 0.
- State codes: WAIT_SYNC=0, SHOW_VID=1, SHOW_TPG=2, MUTE=3, NO_SIGNAL=4.
- Transitions:
  - WAIT_SYNC --fs--> SHOW_TPG if sel_s, else SHOW_VID.
  - SHOW_VID --fs & (sel_s | uf_flag)--> MUTE, target = TPG; forced = uf_flag.
  - SHOW_TPG --fs & !sel_s & (!forced | clean_cnt >= UF_HOLD_FRAMES)--> MUTE, target = VID.
  - MUTE: mute_cnt increments on each fs. On the fs where mute_cnt reaches MUTE_FRAMES, enter target state and clear mute_cnt.
  - MUTE_FRAMES=0: SHOW_* goes directly to target on the same fs.
  - Any state except WAIT_SYNC: no fs for VS_TIMEOUT consecutive cycles -> NO_SIGNAL (takes effect immediately, mid-frame).
  - NO_SIGNAL --fs--> WAIT_SYNC handling on the same fs, i.e. next state chosen as from WAIT_SYNC.
- uf_flag: set by any in_underflow=1 cycle within the current frame; cleared at fs after it has been sampled.
- clean_cnt: in SHOW_TPG, increments (saturating) on each fs whose frame had uf_flag=0; reset to 0 by an underflow frame; forced cleared when target = VID.
- Simultaneous events:
  - Timeout and fs on the same cycle: fs wins; timeout counter reset.
  - sel_s toggling back during MUTE: target is re-evaluated at the final mute fs. If it equals the pre-mute source, return there without a further mute.
- active_src updates in the same cycle out_data changes source; during MUTE it holds target.
- Reset mid-frame: outputs clear asynchronously; resume via WAIT_SYNC.

Decomposition:
- Package tmds_src_pkg: state enum codes, the 8 bar colour constants, SRC_VID/SRC_TPG.
- One sub-module, tpg_colorbar: pixel counter plus bar lookup, inputs de/data-enable, output 24-bit colour.

Test Plan:
- Reset, then 3 frames of H_ACTIVE=1280, sel_tpg=0 -> state 0 until first fs, then 1; out_data equals in_data delayed 1 cycle; out_hs/vs equal inputs delayed 1.
- sel_tpg 0->1 mid-frame, MUTE_FRAMES=2 -> frame stays video to its end; 2 frames with out_data=0 during DE; then pixels 0..159 = FFFFFF, 160..319 = FFFF00, ..., 1120..1279 = 000000; active_src=1.
- Underflow pulse 1 cycle in frame N, sel_tpg=0 -> MUTE from fs N+1, TPG after mute. Clean frames follow -> back to video only after 4 clean TPG frames plus 2 mute frames.
- Stop in_vs for VS_TIMEOUT(set 1000) cycles -> state 4 at cycle 1000, data 0, timing still passed through. Restart vsync -> SHOW_VID at first fs.
- sel_tpg 0->1 then back to 0 during the first mute frame -> returns to SHOW_VID after mute with no extra mute; active_src ends 0.
- Assert RSTn low mid-line in SHOW_TPG -> all outputs 0 immediately (asynchronous), state 0. Release -> correct source at next fs.

Source files
------------

// File: rtl/tmds_src_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_src_pkg
//  Purpose  : Shared constants for the TMDS source scheduler: FSM state
//             codes, source selector codes and the eight colour-bar values
//             with a lookup helper.
//  Revision : 1.0 - initial release
// ============================================================================
package tmds_src_pkg;

   // FSM state codes (also exported on state_o for debug)
   localparam logic [2:0] ST_WAIT_SYNC = 3'd0;
   localparam logic [2:0] ST_SHOW_VID  = 3'd1;
   localparam logic [2:0] ST_SHOW_TPG  = 3'd2;
   localparam logic [2:0] ST_MUTE      = 3'd3;
   localparam logic [2:0] ST_NO_SIGNAL = 3'd4;

   // Source selector codes
   localparam logic SRC_VID = 1'b0;
   localparam logic SRC_TPG = 1'b1;

   // Colour bars, left to right, packed R[23:16] G[15:8] B[7:0]
   localparam logic [23:0] BAR_WHITE   = 24'hFF_FF_FF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFF_FF_00;
   localparam logic [23:0] BAR_CYAN    = 24'h00_FF_FF;
   localparam logic [23:0] BAR_GREEN   = 24'h00_FF_00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF_00_FF;
   localparam logic [23:0] BAR_RED     = 24'hFF_00_00;
   localparam logic [23:0] BAR_BLUE    = 24'h00_00_FF;
   localparam logic [23:0] BAR_BLACK   = 24'h00_00_00;

   function automatic logic [23:0] bar_colour(input logic [2:0] bar);
      logic [23:0] c;
      case (bar)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_src_sched_tpg_colorbar.sv
`default_nettype none
// ============================================================================
//  Module   : tpg_colorbar
//  Purpose  : Eight-bar colour test pattern locked to the incoming DE.
//             Tracks the pixel index within the active line and returns the
//             colour of the bar that pixel falls in, combinationally, for the
//             same cycle.
//  Ports    : CLK    - pixel clock
//             RSTn   - asynchronous active-low reset
//             de     - data enable of the stream the pattern is locked to
//             colour - 24-bit bar colour for the current pixel
//  Revision : 1.0 - initial release
// ============================================================================
module tpg_colorbar
   import tmds_src_pkg::*;
#(
   parameter int H_ACTIVE = 1280
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        de,
   output logic [23:0] colour
);

   localparam int PW    = (H_ACTIVE > 2) ? $clog2(H_ACTIVE) : 1;
   localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

   logic          de_prev_q, de_prev_d;
   logic [PW-1:0] pix_q, pix_d;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_div;
   logic [2:0]    w_bar;

   always_comb begin
      // The first DE cycle of a line is pixel 0 regardless of the counter.
      w_idx     = (de && !de_prev_q) ? '0 : pix_q;
      de_prev_d = de;
      pix_d     = pix_q;
      if (de) begin
         // Saturate on the last active pixel so over-long lines stay black.
         pix_d = (w_idx == PW'(H_ACTIVE - 1)) ? w_idx : (w_idx + 1'b1);
      end
      // Any remainder of H_ACTIVE/8 falls into the last (black) bar.
      w_div  = w_idx / PW'(BAR_W);
      w_bar  = (w_div > PW'(7)) ? 3'd7 : w_div[2:0];
      colour = bar_colour(w_bar);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         de_prev_q <= 1'b0;
         pix_q     <= '0;
      end else begin
         de_prev_q <= de_prev_d;
         pix_q     <= pix_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tmds_src_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_src_sched
//  Purpose  : Frame-synchronous source scheduler in front of the TMDS
//             encoders. Chooses live video or an internal colour-bar pattern
//             per frame, inserts black mute frames on every source change,
//             forces the pattern on video underflow and blanks when vsync
//             disappears. All outputs are registered, one cycle of latency.
//  Ports    : CLK, RSTn        - pixel clock, async active-low reset
//             in_data/de/hs/vs - video stream from the video output block
//             in_underflow     - underflow flag of the video output block
//             sel_tpg          - asynchronous test-pattern request
//             out_data/de/hs/vs- stream to the encoders (VDE, CD[0], CD[1])
//             active_src       - 0 video, 1 pattern (target while muted)
//             state_o          - FSM state code for debug display
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_src_sched
   import tmds_src_pkg::*;
#(
   parameter int   H_ACTIVE       = 1280,
   parameter int   MUTE_FRAMES    = 2,
   parameter int   VS_TIMEOUT     = 2500000,
   parameter logic VS_POL         = 1'b1,
   parameter int   UF_HOLD_FRAMES = 4
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic [23:0] in_data,
   input  logic        in_de,
   input  logic        in_hs,
   input  logic        in_vs,
   input  logic        in_underflow,
   input  logic        sel_tpg,
   output logic [23:0] out_data,
   output logic        out_de,
   output logic        out_hs,
   output logic        out_vs,
   output logic        active_src,
   output logic [2:0]  state_o
);

   localparam int TW = $clog2(VS_TIMEOUT + 1);
   localparam int MW = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
   localparam int CW = (UF_HOLD_FRAMES > 0) ? $clog2(UF_HOLD_FRAMES + 1) : 1;

   logic          sel_meta_q, sel_meta_d;
   logic          sel_s_q, sel_s_d;
   logic          vs_prev_q, vs_prev_d;
   logic          uf_flag_q, uf_flag_d;
   logic [2:0]    state_q, state_d;
   logic          target_q, target_d;
   logic          forced_q, forced_d;
   logic [MW-1:0] mute_cnt_q, mute_cnt_d;
   logic [CW-1:0] clean_cnt_q, clean_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [23:0]   data_q, data_d;
   logic          de_q, hs_q, vs_q;
   logic          src_q, src_d;

   logic          w_fs;
   logic          w_timeout;
   logic [MW-1:0] w_mute_inc;
   logic [CW-1:0] w_clean_next;
   logic          w_want_tpg;
   logic [23:0]   w_colour;

   tpg_colorbar #(
      .H_ACTIVE (H_ACTIVE)
   ) u_tpg (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .de     (in_de),
      .colour (w_colour)
   );

   always_comb begin
      sel_meta_d = sel_tpg;
      sel_s_d    = sel_meta_q;
      vs_prev_d  = in_vs;

      // Frame start: leading edge of vsync towards its active level.
      w_fs = (in_vs == VS_POL) && (vs_prev_q != VS_POL);

      // Underflow on the frame-start cycle already belongs to the new frame.
      uf_flag_d = w_fs ? in_underflow : (uf_flag_q | in_underflow);

      to_cnt_d  = w_fs ? '0
                : ((to_cnt_q == TW'(VS_TIMEOUT - 1)) ? to_cnt_q : (to_cnt_q + 1'b1));
      w_timeout = !w_fs && (to_cnt_q == TW'(VS_TIMEOUT - 1));

      w_mute_inc   = mute_cnt_q + 1'b1;
      w_clean_next = uf_flag_q ? '0
                   : ((clean_cnt_q == CW'(UF_HOLD_FRAMES)) ? clean_cnt_q : (clean_cnt_q + 1'b1));
      // A forced switch keeps the pattern regardless of the request.
      w_want_tpg   = forced_q | sel_s_q;

      state_d     = state_q;
      target_d    = target_q;
      forced_d    = forced_q;
      mute_cnt_d  = mute_cnt_q;
      clean_cnt_d = clean_cnt_q;

      case (state_q)
         ST_WAIT_SYNC, ST_NO_SIGNAL: begin
            if (w_fs) begin
               state_d     = sel_s_q ? ST_SHOW_TPG : ST_SHOW_VID;
               target_d    = sel_s_q ? SRC_TPG : SRC_VID;
               forced_d    = 1'b0;
               mute_cnt_d  = '0;
               clean_cnt_d = '0;
            end
         end
         ST_SHOW_VID: begin
            if (w_fs && (sel_s_q || uf_flag_q)) begin
               target_d    = SRC_TPG;
               forced_d    = uf_flag_q;
               clean_cnt_d = '0;
               state_d     = (MUTE_FRAMES == 0) ? ST_SHOW_TPG : ST_MUTE;
            end
         end
         ST_SHOW_TPG: begin
            if (w_fs) begin
               clean_cnt_d = w_clean_next;
               if (!sel_s_q && (!forced_q || (w_clean_next >= CW'(UF_HOLD_FRAMES)))) begin
                  target_d = SRC_VID;
                  forced_d = 1'b0;
                  state_d  = (MUTE_FRAMES == 0) ? ST_SHOW_VID : ST_MUTE;
               end
            end
         end
         ST_MUTE: begin
            if (w_fs) begin
               if (w_mute_inc >= MW'(MUTE_FRAMES)) begin
                  // Target is re-evaluated here, so a request withdrawn during
                  // the mute returns to the old source without another mute.
                  mute_cnt_d = '0;
                  target_d   = w_want_tpg ? SRC_TPG : SRC_VID;
                  state_d    = w_want_tpg ? ST_SHOW_TPG : ST_SHOW_VID;
                  if (!w_want_tpg) begin
                     forced_d = 1'b0;
                  end
               end else begin
                  mute_cnt_d = w_mute_inc;
               end
            end
         end
         default: begin
            state_d = ST_WAIT_SYNC;
         end
      endcase

      // Loss of vsync acts immediately, mid-frame.
      if (w_timeout && (state_q != ST_WAIT_SYNC) && (state_q != ST_NO_SIGNAL)) begin
         state_d    = ST_NO_SIGNAL;
         mute_cnt_d = '0;
      end

      // Outputs follow the next state so data, source and state_o switch on
      // the same clock edge.
      case (state_d)
         ST_SHOW_TPG: src_d = SRC_TPG;
         ST_MUTE:     src_d = target_d;
         default:     src_d = SRC_VID;
      endcase

      data_d = '0;
      if (in_de) begin
         if (state_d == ST_SHOW_VID) begin
            data_d = in_data;
         end else if (state_d == ST_SHOW_TPG) begin
            data_d = w_colour;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sel_meta_q  <= 1'b0;
         sel_s_q     <= 1'b0;
         vs_prev_q   <= 1'b0;
         uf_flag_q   <= 1'b0;
         state_q     <= ST_WAIT_SYNC;
         target_q    <= SRC_VID;
         forced_q    <= 1'b0;
         mute_cnt_q  <= '0;
         clean_cnt_q <= '0;
         to_cnt_q    <= '0;
         data_q      <= '0;
         de_q        <= 1'b0;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         src_q       <= 1'b0;
      end else begin
         sel_meta_q  <= sel_meta_d;
         sel_s_q     <= sel_s_d;
         vs_prev_q   <= vs_prev_d;
         uf_flag_q   <= uf_flag_d;
         state_q     <= state_d;
         target_q    <= target_d;
         forced_q    <= forced_d;
         mute_cnt_q  <= mute_cnt_d;
         clean_cnt_q <= clean_cnt_d;
         to_cnt_q    <= to_cnt_d;
         data_q      <= data_d;
         de_q        <= in_de;
         hs_q        <= in_hs;
         vs_q        <= in_vs;
         src_q       <= src_d;
      end
   end

   assign out_data   = data_q;
   assign out_de     = de_q;
   assign out_hs     = hs_q;
   assign out_vs     = vs_q;
   assign active_src = src_q;
   assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_src_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_src_sched
//  Purpose  : Self-checking bench for tmds_src_sched. Frames are generated
//             from a table of per-frame stimulus and expected state/source/
//             data kind; timeout and reset corner cases are hand sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_src_sched;
   import tmds_src_pkg::*;

   localparam int H   = 164;   // bar width 20, bar 7 spans 140..163
   localparam int TO  = 1000;
   localparam int M_VID = 0;
   localparam int M_TPG = 1;
   localparam int M_BLK = 2;
   localparam int N_TBL = 26;

   typedef struct {
      logic       sel;   // sel_tpg level applied mid-frame
      logic       uf;    // one-cycle underflow pulse mid-frame
      logic [2:0] st;    // expected state after this frame's fs
      logic       src;   // expected active_src after fs
      int         mode;  // expected content of active pixels
   } frame_rec_t;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic [23:0] in_data = '0;
   logic        in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0, in_underflow = 1'b0;
   logic        sel_tpg = 1'b0;
   logic [23:0] out_data;
   logic        out_de, out_hs, out_vs, active_src;
   logic [2:0]  state_o;

   always #5 CLK = ~CLK;

   tmds_src_sched #(
      .H_ACTIVE       (H),
      .MUTE_FRAMES    (2),
      .VS_TIMEOUT     (TO),
      .VS_POL         (1'b1),
      .UF_HOLD_FRAMES (4)
   ) dut (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .in_data      (in_data),
      .in_de        (in_de),
      .in_hs        (in_hs),
      .in_vs        (in_vs),
      .in_underflow (in_underflow),
      .sel_tpg      (sel_tpg),
      .out_data     (out_data),
      .out_de       (out_de),
      .out_hs       (out_hs),
      .out_vs       (out_vs),
      .active_src   (active_src),
      .state_o      (state_o)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          fs_cyc = 0;
   int          cur_mode = M_BLK;
   bit          to_arm = 1'b0;
   bit          bnd_arm = 1'b0;
   logic        vs_drv_prev = 1'b0;
   bit          fr_err;
   logic [26:0] fr_act, fr_exp;
   int          fr_cyc;

   frame_rec_t  tbl [N_TBL];
   int          bnd_idx [10];
   logic [23:0] bnd_col [10];

   function automatic frame_rec_t mk(input logic sel, input logic uf, input logic [2:0] st,
                                     input logic src, input int mode);
      frame_rec_t r;
      r.sel = sel; r.uf = uf; r.st = st; r.src = src; r.mode = mode;
      return r;
   endfunction

   function automatic logic [23:0] ref_colour(input int idx);
      logic [23:0] c;
      if      (idx < 20)  c = 24'hFFFFFF;
      else if (idx < 40)  c = 24'hFFFF00;
      else if (idx < 60)  c = 24'h00FFFF;
      else if (idx < 80)  c = 24'h00FF00;
      else if (idx < 100) c = 24'hFF00FF;
      else if (idx < 120) c = 24'hFF0000;
      else if (idx < 140) c = 24'h0000FF;
      else                c = 24'h000000;
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle, then check the registered outputs just after the edge.
   task automatic step(input logic de, input logic hs, input logic vs, input logic uf,
                       input int idx);
      logic [23:0] d;
      logic [23:0] exp_d;
      int          k;
      d = 24'($urandom);
      in_data = d; in_de = de; in_hs = hs; in_vs = vs; in_underflow = uf;
      if (vs && !vs_drv_prev) fs_cyc = cyc;
      vs_drv_prev = vs;
      @(posedge CLK);
      #1;
      k = cyc - fs_cyc;
      if (to_arm && k >= TO) cur_mode = M_BLK;
      if (to_arm && k == TO - 1) chk("state one cycle before timeout", 32'(state_o), 32'd1);
      if (to_arm && k == TO)     chk("state at timeout", 32'(state_o), 32'd4);
      exp_d = '0;
      if (de) begin
         case (cur_mode)
            M_VID:   exp_d = d;
            M_TPG:   exp_d = ref_colour(idx);
            default: exp_d = '0;
         endcase
      end
      if ({out_de, out_hs, out_vs, out_data} !== {de, hs, vs, exp_d}) begin
         if (!fr_err) begin
            fr_act = {out_de, out_hs, out_vs, out_data};
            fr_exp = {de, hs, vs, exp_d};
            fr_cyc = cyc;
         end
         fr_err = 1'b1;
      end
      if (bnd_arm && de) begin
         for (int i = 0; i < 10; i++) begin
            if (idx == bnd_idx[i]) chk($sformatf("bar pixel %0d", idx), 32'(out_data), 32'(bnd_col[i]));
         end
      end
      cyc++;
   endtask

   task automatic line();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < H; i++) step(1'b1, 1'b0, 1'b0, 1'b0, i);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic stream_chk(input string name);
      n_cmp++;
      if (fr_err) begin
         n_bad++;
         $display("FAIL %s stream: cycle %0d got de/hs/vs/data %h expected %h",
                  name, fr_cyc, fr_act, fr_exp);
      end
      fr_err = 1'b0;
   endtask

   task automatic frame(input int n, input frame_rec_t r);
      fr_err   = 1'b0;
      cur_mode = r.mode;
      step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk($sformatf("frame %0d state", n), 32'(state_o), 32'(r.st));
      chk($sformatf("frame %0d active_src", n), 32'(active_src), 32'(r.src));
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      line();
      sel_tpg = r.sel;
      step(1'b0, 1'b0, 1'b0, r.uf, 0);
      line();
      stream_chk($sformatf("frame %0d", n));
   endtask

   initial begin
      tbl[0]  = mk(1'b0, 1'b0, 3'd1, 1'b0, M_VID);
      tbl[1]  = mk(1'b0, 1'b0, 3'd1, 1'b0, M_VID);
      tbl[2]  = mk(1'b1, 1'b0, 3'd1, 1'b0, M_VID);
      tbl[3]  = mk(1'b1, 1'b0, 3'd3, 1'b1, M_BLK);
      tbl[4]  = mk(1'b1, 1'b0, 3'd3, 1'b1, M_BLK);
      tbl[5]  = mk(1'b1, 1'b0, 3'd2, 1'b1, M_TPG);
      tbl[6]  = mk(1'b0, 1'b0, 3'd2, 1'b1, M_TPG);
      tbl[7]  = mk(1'b0, 1'b0, 3'd3, 1'b0, M_BLK);
      tbl[8]  = mk(1'b0, 1'b0, 3'd3, 1'b0, M_BLK);
      tbl[9]  = mk(1'b0, 1'b0, 3'd1, 1'b0, M_VID);
      tbl[10] = mk(1'b0, 1'b1, 3'd1, 1'b0, M_VID);
      tbl[11] = mk(1'b0, 1'b0, 3'd3, 1'b1, M_BLK);
      tbl[12] = mk(1'b0, 1'b0, 3'd3, 1'b1, M_BLK);
      tbl[13] = mk(1'b0, 1'b1, 3'd2, 1'b1, M_TPG);
      tbl[14] = mk(1'b0, 1'b0, 3'd2, 1'b1, M_TPG);
      tbl[15] = mk(1'b0, 1'b0, 3'd2, 1'b1, M_TPG);
      tbl[16] = mk(1'b0, 1'b0, 3'd2, 1'b1, M_TPG);
      tbl[17] = mk(1'b0, 1'b0, 3'd2, 1'b1, M_TPG);
      tbl[18] = mk(1'b0, 1'b0, 3'd3, 1'b0, M_BLK);
      tbl[19] = mk(1'b0, 1'b0, 3'd3, 1'b0, M_BLK);
      tbl[20] = mk(1'b0, 1'b0, 3'd1, 1'b0, M_VID);
      tbl[21] = mk(1'b1, 1'b0, 3'd1, 1'b0, M_VID);
      tbl[22] = mk(1'b0, 1'b0, 3'd3, 1'b1, M_BLK);
      tbl[23] = mk(1'b0, 1'b0, 3'd3, 1'b1, M_BLK);
      tbl[24] = mk(1'b0, 1'b0, 3'd1, 1'b0, M_VID);
      tbl[25] = mk(1'b0, 1'b0, 3'd1, 1'b0, M_VID);

      bnd_idx = '{0, 19, 20, 59, 60, 119, 120, 139, 140, 163};
      bnd_col = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                  24'hFF0000, 24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000};

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      chk("reset outputs", {out_data, out_de, out_hs, out_vs, active_src}, 32'd0);
      chk("reset state", 32'(state_o), 32'd0);
      #2 RSTn = 1'b1;

      // No vsync yet: stay in WAIT_SYNC, pixels black
      fr_err   = 1'b0;
      cur_mode = M_BLK;
      line();
      stream_chk("wait_sync line");
      chk("state before first fs", 32'(state_o), 32'd0);

      for (int i = 0; i < N_TBL; i++) begin
         bnd_arm = (i == 5);
         frame(i, tbl[i]);
      end
      bnd_arm = 1'b0;

      // vsync stops after frame 25
      fr_err = 1'b0;
      to_arm = 1'b1;
      repeat (5) line();
      stream_chk("vsync loss");
      chk("state after vsync loss", 32'(state_o), 32'd4);
      to_arm = 1'b0;
      frame(26, mk(1'b0, 1'b0, 3'd1, 1'b0, M_VID));
      frame(27, mk(1'b1, 1'b0, 3'd1, 1'b0, M_VID));
      frame(28, mk(1'b1, 1'b0, 3'd3, 1'b1, M_BLK));
      frame(29, mk(1'b1, 1'b0, 3'd3, 1'b1, M_BLK));

      // Partial TPG frame, then reset mid-line
      fr_err   = 1'b0;
      cur_mode = M_TPG;
      step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("pre-reset state", 32'(state_o), 32'd2);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b0, i);
      stream_chk("pre-reset line");
      chk("active_src before reset", 32'(active_src), 32'd1);
      #2 RSTn = 1'b0;
      #1;
      chk("async reset outputs", {out_data, out_de, out_hs, out_vs, active_src}, 32'd0);
      chk("async reset state", 32'(state_o), 32'd0);
      in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; vs_drv_prev = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RSTn = 1'b1;
      cur_mode = M_BLK;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      stream_chk("post-reset idle");
      chk("post-reset state", 32'(state_o), 32'd0);
      frame(30, mk(1'b1, 1'b0, 3'd2, 1'b1, M_TPG));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
